// File: rtl/dual_lane_collector_if.sv
// Bundle between the two-lane pipeline, the collector and the merged-stream consumer.
// The slave view is the collector; the master view drives lane beats and m_ready.
interface dual_lane_collector_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] pipeline1_outputs;
   logic [DATA_W-1:0] pipeline2_outputs;
   logic [1:0]        out_valid;
   logic              flush_1;
   logic              flush_2;
   logic [DATA_W-1:0] m_data;
   logic              m_lane;
   logic              m_valid;
   logic              m_ready;
   logic [LW-1:0]     level1;
   logic [LW-1:0]     level2;
   logic [1:0]        overflow;

   modport master (
      output pipeline1_outputs,
      output pipeline2_outputs,
      output out_valid,
      output flush_1,
      output flush_2,
      output m_ready,
      input  m_data,
      input  m_lane,
      input  m_valid,
      input  level1,
      input  level2,
      input  overflow
   );

   modport slave (
      input  pipeline1_outputs,
      input  pipeline2_outputs,
      input  out_valid,
      input  flush_1,
      input  flush_2,
      input  m_ready,
      output m_data,
      output m_lane,
      output m_valid,
      output level1,
      output level2,
      output overflow
   );

endinterface

// File: rtl/dual_lane_collector.sv
// Receive end of the two-lane pipeline: one FIFO per lane, merged into a single
// valid/ready stream by a round-robin arbiter feeding a registered output stage.
// The producer cannot be stalled, so a beat arriving at a full lane is dropped
// and flagged in a sticky per-lane overflow bit.
//
// Arbiter state (rr_last):
//   state | meaning
//   LAST1 | lane 1 won the most recent grant; a tie next goes to lane 2
//   LAST2 | lane 2 won the most recent grant; a tie next goes to lane 1
module dual_lane_collector #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input logic                  clk,
   input logic                  reset,
   dual_lane_collector_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {
      LAST1 = 1'b0,
      LAST2 = 1'b1
   } rr_state_t;

   logic [DATA_W-1:0] mem1 [DEPTH];
   logic [DATA_W-1:0] mem2 [DEPTH];

   logic [AW-1:0]     wr1;
   logic [AW-1:0]     rd1;
   logic [AW-1:0]     wr2;
   logic [AW-1:0]     rd2;
   logic [LW-1:0]     lvl1;
   logic [LW-1:0]     lvl2;

   rr_state_t         rr_last;
   logic [DATA_W-1:0] m_data_r;
   logic              m_lane_r;
   logic              m_valid_r;
   logic [1:0]        ovf_r;

   logic              load;
   logic              ne1;
   logic              ne2;
   logic              grant1;
   logic              grant2;
   logic              push1;
   logic              push2;
   logic              drop1;
   logic              drop2;

   // Grant, push and drop decisions for the coming edge.
   // A lane being flushed is treated as empty so its pop is cancelled and the
   // other lane may still be served in the same cycle.
   always_comb begin
      load   = !m_valid_r || bus.m_ready;
      ne1    = (lvl1 != '0) && !bus.flush_1;
      ne2    = (lvl2 != '0) && !bus.flush_2;
      grant1 = 1'b0;
      grant2 = 1'b0;
      if (load) begin
         if (ne1 && ne2) begin
            grant1 = (rr_last == LAST2);
            grant2 = (rr_last == LAST1);
         end else begin
            grant1 = ne1;
            grant2 = ne2;
         end
      end
      push1 = bus.out_valid[0] && !bus.flush_1 && ((lvl1 != LW'(DEPTH)) || grant1);
      push2 = bus.out_valid[1] && !bus.flush_2 && ((lvl2 != LW'(DEPTH)) || grant2);
      drop1 = bus.out_valid[0] && !bus.flush_1 && !push1;
      drop2 = bus.out_valid[1] && !bus.flush_2 && !push2;
   end

   // Lane storage; no reset needed since occupancy is tracked by the levels.
   always_ff @(posedge clk) begin
      if (push1) begin
         mem1[wr1] <= bus.pipeline1_outputs;
      end
      if (push2) begin
         mem2[wr2] <= bus.pipeline2_outputs;
      end
   end

   // Pointers, levels, overflow flags, arbiter state and the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr1       <= '0;
         rd1       <= '0;
         wr2       <= '0;
         rd2       <= '0;
         lvl1      <= '0;
         lvl2      <= '0;
         ovf_r     <= '0;
         rr_last   <= LAST1;
         m_data_r  <= '0;
         m_lane_r  <= 1'b0;
         m_valid_r <= 1'b0;
      end else begin
         if (bus.flush_1) begin
            wr1  <= '0;
            rd1  <= '0;
            lvl1 <= '0;
         end else begin
            if (push1) begin
               wr1 <= wr1 + AW'(1);
            end
            if (grant1) begin
               rd1 <= rd1 + AW'(1);
            end
            case ({push1, grant1})
               2'b10:   lvl1 <= lvl1 + LW'(1);
               2'b01:   lvl1 <= lvl1 - LW'(1);
               default: lvl1 <= lvl1;
            endcase
         end

         if (bus.flush_2) begin
            wr2  <= '0;
            rd2  <= '0;
            lvl2 <= '0;
         end else begin
            if (push2) begin
               wr2 <= wr2 + AW'(1);
            end
            if (grant2) begin
               rd2 <= rd2 + AW'(1);
            end
            case ({push2, grant2})
               2'b10:   lvl2 <= lvl2 + LW'(1);
               2'b01:   lvl2 <= lvl2 - LW'(1);
               default: lvl2 <= lvl2;
            endcase
         end

         if (drop1) begin
            ovf_r[0] <= 1'b1;
         end
         if (drop2) begin
            ovf_r[1] <= 1'b1;
         end

         if (grant1) begin
            m_data_r  <= mem1[rd1];
            m_lane_r  <= 1'b0;
            m_valid_r <= 1'b1;
            rr_last   <= LAST1;
         end else if (grant2) begin
            m_data_r  <= mem2[rd2];
            m_lane_r  <= 1'b1;
            m_valid_r <= 1'b1;
            rr_last   <= LAST2;
         end else if (m_valid_r && bus.m_ready) begin
            m_valid_r <= 1'b0;
         end
      end
   end

   assign bus.m_data   = m_data_r;
   assign bus.m_lane   = m_lane_r;
   assign bus.m_valid  = m_valid_r;
   assign bus.level1   = lvl1;
   assign bus.level2   = lvl2;
   assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_dual_lane_collector.sv
// Bench for dual_lane_collector: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the collector.
module tb_dual_lane_collector;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic reset;

   int checks = 0;
   int errors = 0;

   dual_lane_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   dual_lane_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference state: lane queues, output register, last granted lane, sticky flags.
   logic [DATA_W-1:0] q1[$];
   logic [DATA_W-1:0] q2[$];
   bit                mv;
   logic [DATA_W-1:0] md;
   bit                ml;
   bit                last_was_2;
   bit [1:0]          ovf;
   logic [DATA_W:0]   outlog[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit [1:0] v, input logic [DATA_W-1:0] d1,
                             input logic [DATA_W-1:0] d2, input bit f1, input bit f2, input bit rdy);
      bit consume, load, e1, e2;
      int g;
      if (rst) begin
         q1.delete();
         q2.delete();
         mv = 0; md = '0; ml = 0; last_was_2 = 0; ovf = 2'b00;
         return;
      end
      consume = mv && rdy;
      if (consume) outlog.push_back({ml, md});
      load = !mv || rdy;
      e1 = (q1.size() > 0) && !f1;
      e2 = (q2.size() > 0) && !f2;
      g = 0;
      if (load) begin
         if (e1 && e2) g = last_was_2 ? 1 : 2;
         else if (e1) g = 1;
         else if (e2) g = 2;
      end
      if (g == 1) begin
         md = q1.pop_front(); ml = 0; mv = 1; last_was_2 = 0;
      end else if (g == 2) begin
         md = q2.pop_front(); ml = 1; mv = 1; last_was_2 = 1;
      end else if (consume) begin
         mv = 0;
      end
      if (f1) q1.delete();
      if (f2) q2.delete();
      if (v[0] && !f1) begin
         if (q1.size() < DEPTH) q1.push_back(d1);
         else ovf[0] = 1;
      end
      if (v[1] && !f2) begin
         if (q2.size() < DEPTH) q2.push_back(d2);
         else ovf[1] = 1;
      end
   endtask

   task automatic compare_all();
      chk("m_valid", 64'(bus.m_valid), 64'(mv));
      if (mv) begin
         chk("m_data", 64'(bus.m_data), 64'(md));
         chk("m_lane", 64'(bus.m_lane), 64'(ml));
      end
      chk("level1", 64'(bus.level1), 64'(q1.size()));
      chk("level2", 64'(bus.level2), 64'(q2.size()));
      chk("overflow", 64'(bus.overflow), 64'(ovf));
   endtask

   task automatic step(input bit rst, input bit [1:0] v, input logic [DATA_W-1:0] d1,
                       input logic [DATA_W-1:0] d2, input bit f1, input bit f2, input bit rdy);
      reset                 = rst;
      bus.out_valid         = v;
      bus.pipeline1_outputs = d1;
      bus.pipeline2_outputs = d2;
      bus.flush_1           = f1;
      bus.flush_2           = f2;
      bus.m_ready           = rdy;
      @(posedge clk);
      model_edge(rst, v, d1, d2, f1, f2, rdy);
      #1;
      compare_all();
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int k = 0; k < n; k++) step(0, 2'b00, '0, '0, 0, 0, rdy);
   endtask

   logic [DATA_W:0] exp3 [8];

   initial begin
      reset = 1'b1;
      bus.out_valid = 2'b00;
      bus.pipeline1_outputs = '0;
      bus.pipeline2_outputs = '0;
      bus.flush_1 = 1'b0;
      bus.flush_2 = 1'b0;
      bus.m_ready = 1'b0;
      #1;

      // Reset state
      step(1, 2'b00, '0, '0, 0, 0, 0);
      step(1, 2'b00, '0, '0, 0, 0, 0);
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_overflow", 64'(bus.overflow), 64'd0);

      // Single lane-1 beat: two clocks to output
      outlog.delete();
      step(0, 2'b01, 32'hA5A5_0001, '0, 0, 0, 1);
      chk("t1_level1_a", 64'(bus.level1), 64'd1);
      chk("t1_valid_a", 64'(bus.m_valid), 64'd0);
      step(0, 2'b00, '0, '0, 0, 0, 1);
      chk("t1_valid_b", 64'(bus.m_valid), 64'd1);
      chk("t1_data", 64'(bus.m_data), 64'hA5A5_0001);
      chk("t1_lane", 64'(bus.m_lane), 64'd0);
      chk("t1_level1_b", 64'(bus.level1), 64'd0);
      idle(1, 2);

      // Lane 2 burst into a stalled consumer: one beat beyond capacity is dropped
      outlog.delete();
      for (int i = 0; i < 6; i++) step(0, 2'b10, '0, 32'h10 + 32'(i), 0, 0, 0);
      chk("t2_level2", 64'(bus.level2), 64'd4);
      chk("t2_overflow", 64'(bus.overflow), 64'b10);
      chk("t2_held", 64'(bus.m_data), 64'h10);
      idle(1, 8);
      chk("t2_count", 64'(outlog.size()), 64'd5);
      for (int i = 0; i < 5 && i < outlog.size(); i++)
         chk("t2_order", 64'(outlog[i]), {31'd0, 1'b1, 32'h10 + 32'(i)});

      // Both lanes loaded, then drained: lanes alternate
      outlog.delete();
      for (int i = 0; i < 4; i++) step(0, 2'b11, 32'h100 + 32'(i), 32'h200 + 32'(i), 0, 0, 0);
      idle(1, 10);
      exp3 = '{{1'b0, 32'h100}, {1'b1, 32'h200}, {1'b0, 32'h101}, {1'b1, 32'h201},
               {1'b0, 32'h102}, {1'b1, 32'h202}, {1'b0, 32'h103}, {1'b1, 32'h203}};
      chk("t3_count", 64'(outlog.size()), 64'd8);
      for (int i = 0; i < 8 && i < outlog.size(); i++)
         chk("t3_order", 64'(outlog[i]), 64'(exp3[i]));

      // Flush lane 1 with a concurrent beat; held output survives
      outlog.delete();
      for (int i = 0; i < 3; i++) step(0, 2'b01, 32'h300 + 32'(i), '0, 0, 0, 0);
      step(0, 2'b01, 32'hDEAD, '0, 1, 0, 0);
      chk("t4_level1", 64'(bus.level1), 64'd0);
      chk("t4_ovf0", 64'(bus.overflow[0]), 64'd0);
      chk("t4_held", 64'(bus.m_data), 64'h300);
      chk("t4_held_v", 64'(bus.m_valid), 64'd1);
      idle(1, 4);
      chk("t4_count", 64'(outlog.size()), 64'd1);
      if (outlog.size() > 0) chk("t4_beat", 64'(outlog[0]), 64'h300);

      // Reset with both lanes occupied
      for (int i = 0; i < 3; i++) step(0, 2'b11, 32'h400 + 32'(i), 32'h500 + 32'(i), 0, 0, 0);
      step(1, 2'b00, '0, '0, 0, 0, 0);
      chk("t5_valid", 64'(bus.m_valid), 64'd0);
      chk("t5_level1", 64'(bus.level1), 64'd0);
      chk("t5_level2", 64'(bus.level2), 64'd0);
      chk("t5_overflow", 64'(bus.overflow), 64'd0);

      // Sustained lane-1 stream at one beat per clock
      outlog.delete();
      for (int i = 0; i < 16; i++) begin
         step(0, 2'b01, 32'(i), '0, 0, 0, 1);
         chk("t6_level_le1", 64'(bus.level1 <= 1), 64'd1);
         if (i >= 1) chk("t6_stream", 64'(bus.m_data), 64'(i - 1));
      end
      idle(1, 3);
      chk("t6_count", 64'(outlog.size()), 64'd16);
      for (int i = 0; i < 16 && i < outlog.size(); i++)
         chk("t6_order", 64'(outlog[i]), 64'(i));

      // Random traffic against the reference
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 2) != 0) : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
